// File: rtl/card_pkg.sv
// Shared deck constants, FSM state encoding and LFSR step for the card dealer.
package card_pkg;

    localparam int DECK_SIZE = 52;
    localparam int SUIT_SIZE = 13;
    localparam int IDX_W     = 6;
    localparam int SUIT_W    = 2;
    localparam int RANK_W    = 4;
    localparam int LFSR_W    = 8;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PICK  = 2'd1,
        PROBE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        lfsr_next = {1'b0, v[LFSR_W-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/card_decode.sv
// Combinational card index decoder: 0..51 -> suit (index / 13) and rank (index % 13).
module card_decode
    import card_pkg::*;
(
    input  logic [IDX_W-1:0]  i_idx,
    output logic [SUIT_W-1:0] o_suit,
    output logic [RANK_W-1:0] o_rank
);

    logic [IDX_W-1:0] w_base;

    // Threshold compares replace the divider; the rank is the offset from the suit base.
    always_comb begin
        o_suit = 2'd0;
        w_base = 6'd0;
        if (i_idx >= 6'd39) begin
            o_suit = 2'd3;
            w_base = 6'd39;
        end else if (i_idx >= 6'd26) begin
            o_suit = 2'd2;
            w_base = 6'd26;
        end else if (i_idx >= 6'd13) begin
            o_suit = 2'd1;
            w_base = 6'd13;
        end
        o_rank = RANK_W'(i_idx - w_base);
    end

endmodule

// File: rtl/card_dealer.sv
// Deals unique cards from a 52-card deck: LFSR pick, linear probe over a used mask,
// decoded result returned with a one-cycle acknowledge.
module card_dealer
    import card_pkg::*;
#(
    parameter int          NUM_PLAYERS = 4,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            new_round,
    input  logic                            deal_req,
    input  logic [$clog2(NUM_PLAYERS)-1:0]  deal_player,
    output logic                            deal_ack,
    output logic                            deal_nack,
    output logic [5:0]                      card_bit,
    output logic [1:0]                      card_flower,
    output logic [3:0]                      card_number,
    output logic [$clog2(NUM_PLAYERS)-1:0]  card_player,
    output logic [5:0]                      cards_left,
    output logic                            deck_empty,
    output logic [4*NUM_PLAYERS-1:0]        hand_count,
    output logic                            busy
);

    localparam int PID_W = $clog2(NUM_PLAYERS);

    state_t                    r_state;
    logic [LFSR_W-1:0]         r_lfsr;
    logic [DECK_SIZE-1:0]      r_used;
    logic [IDX_W-1:0]          r_cand;
    logic [PID_W-1:0]          r_player;
    logic                      r_ack;
    logic                      r_nack;
    logic [IDX_W-1:0]          r_card_bit;
    logic [SUIT_W-1:0]         r_flower;
    logic [RANK_W-1:0]         r_number;
    logic [PID_W-1:0]          r_card_player;
    logic [IDX_W-1:0]          r_cards_left;
    logic [4*NUM_PLAYERS-1:0]  r_hand;

    logic [IDX_W-1:0]          w_raw;
    logic [IDX_W-1:0]          w_pick;
    logic [IDX_W-1:0]          w_next_cand;
    logic [SUIT_W-1:0]         w_suit;
    logic [RANK_W-1:0]         w_rank;
    logic                      w_deck_empty;
    logic [4*NUM_PLAYERS-1:0]  w_hand_inc;

    // Fold the 6-bit LFSR slice (0..63) into the deck range with one subtract.
    assign w_raw        = r_lfsr[IDX_W-1:0];
    assign w_pick       = (w_raw < 6'(DECK_SIZE)) ? w_raw : w_raw - 6'(DECK_SIZE);
    assign w_next_cand  = (r_cand == 6'(DECK_SIZE - 1)) ? 6'd0 : r_cand + 6'd1;
    assign w_deck_empty = (r_cards_left == 6'd0);

    card_decode u_decode (
        .i_idx  (r_cand),
        .o_suit (w_suit),
        .o_rank (w_rank)
    );

    always_comb begin
        w_hand_inc = r_hand;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (r_player == PID_W'(p) && r_hand[4*p +: 4] != 4'hF)
                w_hand_inc[4*p +: 4] = r_hand[4*p +: 4] + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_lfsr        <= LFSR_SEED;
            r_used        <= '0;
            r_cand        <= '0;
            r_player      <= '0;
            r_ack         <= 1'b0;
            r_nack        <= 1'b0;
            r_card_bit    <= '0;
            r_flower      <= '0;
            r_number      <= '0;
            r_card_player <= '0;
            r_cards_left  <= 6'(DECK_SIZE);
            r_hand        <= '0;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
            r_ack  <= 1'b0;
            r_nack <= 1'b0;
            // A new round overrides whatever deal is in flight; card outputs are left as-is.
            if (new_round) begin
                r_used       <= '0;
                r_cards_left <= 6'(DECK_SIZE);
                r_hand       <= '0;
                r_state      <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (deal_req) begin
                            if (w_deck_empty) begin
                                r_nack <= 1'b1;
                            end else begin
                                r_player <= deal_player;
                                r_state  <= PICK;
                            end
                        end
                    end
                    PICK: begin
                        r_cand  <= w_pick;
                        r_state <= PROBE;
                    end
                    PROBE: begin
                        // Terminates: PROBE is only reached while at least one slot is free.
                        if (!r_used[r_cand]) begin
                            r_used[r_cand] <= 1'b1;
                            r_state        <= DONE;
                        end else begin
                            r_cand <= w_next_cand;
                        end
                    end
                    DONE: begin
                        r_card_bit    <= r_cand;
                        r_flower      <= w_suit;
                        r_number      <= w_rank;
                        r_card_player <= r_player;
                        r_ack         <= 1'b1;
                        r_cards_left  <= r_cards_left - 6'd1;
                        r_hand        <= w_hand_inc;
                        r_state       <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign deal_ack    = r_ack;
    assign deal_nack   = r_nack;
    assign card_bit    = r_card_bit;
    assign card_flower = r_flower;
    assign card_number = r_number;
    assign card_player = r_card_player;
    assign cards_left  = r_cards_left;
    assign deck_empty  = w_deck_empty;
    assign hand_count  = r_hand;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: the driver pushes expected responses, a negedge monitor checks them.
module tb_card_dealer;

    localparam int         NP   = 4;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_round = 1'b0;
    logic        deal_req = 1'b0;
    logic [1:0]  deal_player = 2'd0;
    logic        deal_ack, deal_nack, deck_empty, busy;
    logic [5:0]  card_bit, cards_left;
    logic [1:0]  card_flower, card_player;
    logic [3:0]  card_number;
    logic [15:0] hand_count;

    card_dealer #(.NUM_PLAYERS(NP), .LFSR_SEED(SEED)) dut (
        .clk         (clk),
        .rst         (rst),
        .new_round   (new_round),
        .deal_req    (deal_req),
        .deal_player (deal_player),
        .deal_ack    (deal_ack),
        .deal_nack   (deal_nack),
        .card_bit    (card_bit),
        .card_flower (card_flower),
        .card_number (card_number),
        .card_player (card_player),
        .cards_left  (cards_left),
        .deck_empty  (deck_empty),
        .hand_count  (hand_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef enum int {K_ACK = 0, K_NACK = 1, K_STAT = 2} kind_t;
    typedef struct {
        kind_t       kind;
        int          cyc;
        int          issue;
        int          card;
        int          flower;
        int          number;
        int          player;
        int          left;
        logic [15:0] hand;
        int          busy;
        bit          chk_card;
        int          run;
        int          idx;
    } exp_t;

    exp_t q[$];

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting right, reloaded while rst is high.
    function automatic logic [7:0] ref_lfsr(input logic [7:0] v);
        logic [7:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 8'b1011_1000;
        return r;
    endfunction

    int         cyc = 0;
    logic [7:0] m_lfsr;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= rst ? SEED : ref_lfsr(m_lfsr);
    end

    bit m_used [52];
    int m_left;
    int m_hand [NP];
    int m_card, m_flower, m_number, m_player;
    int run;

    function automatic logic [15:0] pack_hand();
        logic [15:0] h;
        h = '0;
        for (int p = 0; p < NP; p++) h[4*p +: 4] = 4'(m_hand[p]);
        return h;
    endfunction

    function automatic exp_t blank();
        exp_t b;
        b.kind = K_STAT; b.cyc = 0; b.issue = 0; b.card = 0; b.flower = 0;
        b.number = 0; b.player = 0; b.left = 0; b.hand = '0; b.busy = 0;
        b.chk_card = 1'b0; b.run = 0; b.idx = 0;
        return b;
    endfunction

    function automatic exp_t status(input int c, input int bsy, input bit with_card);
        exp_t s;
        s = blank();
        s.cyc = c; s.busy = bsy; s.left = m_left; s.hand = pack_hand();
        s.chk_card = with_card;
        s.card = m_card; s.flower = m_flower; s.number = m_number; s.player = m_player;
        return s;
    endfunction

    task automatic clear_model(input bit full);
        for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
        for (int p = 0; p < NP; p++) m_hand[p] = 0;
        m_left = 52;
        if (full) begin
            m_card = 0; m_flower = 0; m_number = 0; m_player = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model(1'b1);
        q.push_back(status(cyc, 0, 1'b1));
    endtask

    task automatic do_deal(input int p, input int rn, input int idx);
        exp_t e;
        int   c, k, n;
        @(posedge clk); #1;
        deal_req    = 1'b1;
        deal_player = 2'(p);
        @(posedge clk); #1;
        n = cyc;
        e = blank();
        e.issue = n; e.run = rn; e.idx = idx;
        if (m_left == 0) begin
            e.kind = K_NACK;
            e.cyc  = n;
            q.push_back(e);
            q.push_back(status(n + 1, 0, 1'b1));
        end else begin
            q.push_back(status(n, 1, 1'b0));
            c = int'(m_lfsr[5:0]);
            if (c >= 52) c = c - 52;
            k = 0;
            for (int t = 0; t < 52 && m_used[c]; t++) begin
                c = (c == 51) ? 0 : c + 1;
                k++;
            end
            m_used[c] = 1'b1;
            m_left    = m_left - 1;
            if (m_hand[p] < 15) m_hand[p] = m_hand[p] + 1;
            m_card = c; m_flower = c / 13; m_number = c % 13; m_player = p;
            e.kind = K_ACK; e.cyc = n + 3 + k;
            e.card = c; e.flower = c / 13; e.number = c % 13; e.player = p;
            e.left = m_left; e.hand = pack_hand();
            q.push_back(e);
        end
        deal_player = 2'(p + 1);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (deal_ack || deal_nack) break;
        end
        deal_req = 1'b0;
    endtask

    task automatic nr_pulse(input bit with_req);
        @(posedge clk); #1;
        new_round = 1'b1;
        deal_req  = with_req;
        @(posedge clk); #1;
        new_round = 1'b0;
        deal_req  = 1'b0;
        clear_model(1'b0);
        q.push_back(status(cyc, 0, 1'b1));
    endtask

    task automatic nr_abort(input int p);
        @(posedge clk); #1;
        deal_req    = 1'b1;
        deal_player = 2'(p);
        @(posedge clk); #1;
        @(posedge clk); #1;
        new_round = 1'b1;
        deal_req  = 1'b0;
        @(posedge clk); #1;
        new_round = 1'b0;
        clear_model(1'b0);
        q.push_back(status(cyc, 0, 1'b1));
    endtask

    task automatic rst_abort();
        @(posedge clk); #1;
        deal_req    = 1'b1;
        deal_player = 2'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        deal_req = 1'b0;
        do_reset();
    endtask

    // Monitor side: the only writer of the counters.
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t h;
    bit   seen [52];
    int   first_run [8];
    int   dec_idx [5] = '{0, 12, 13, 38, 51};
    int   dec_f   [5] = '{0, 0, 1, 2, 3};
    int   dec_n   [5] = '{0, 12, 0, 12, 12};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].kind == K_STAT && q[0].cyc <= cyc) begin
            h = q.pop_front();
            chk("stat_cycle", cyc, h.cyc);
            chk("stat_busy", int'(busy), h.busy);
            chk("stat_ack_low", int'(deal_ack), 0);
            chk("stat_nack_low", int'(deal_nack), 0);
            chk("stat_cards_left", int'(cards_left), h.left);
            chk("stat_deck_empty", int'(deck_empty), (h.left == 0) ? 1 : 0);
            chk("stat_hand_count", int'(hand_count), int'(h.hand));
            if (h.chk_card) begin
                chk("stat_card_bit", int'(card_bit), h.card);
                chk("stat_card_flower", int'(card_flower), h.flower);
                chk("stat_card_number", int'(card_number), h.number);
                chk("stat_card_player", int'(card_player), h.player);
            end
        end
        if (deal_ack || deal_nack) begin
            if (q.size() == 0 || q[0].kind == K_STAT) begin
                chk("unexpected_ack", int'(deal_ack), 0);
                chk("unexpected_nack", int'(deal_nack), 0);
            end else begin
                h = q.pop_front();
                chk("event_kind", deal_ack ? int'(K_ACK) : int'(K_NACK), int'(h.kind));
                chk("event_cycle", cyc, h.cyc);
                if (h.kind == K_ACK) begin
                    chk("ack_nack_exclusive", int'(deal_nack), 0);
                    chk("latency_bound", ((cyc - h.issue) <= 54) ? 1 : 0, 1);
                    chk("card_bit", int'(card_bit), h.card);
                    chk("card_flower", int'(card_flower), h.flower);
                    chk("card_number", int'(card_number), h.number);
                    chk("card_player", int'(card_player), h.player);
                    chk("cards_left", int'(cards_left), h.left);
                    chk("deck_empty", int'(deck_empty), (h.left == 0) ? 1 : 0);
                    chk("hand_count", int'(hand_count), int'(h.hand));
                    for (int i = 0; i < 5; i++) begin
                        if (int'(card_bit) == dec_idx[i]) begin
                            chk("decode_flower", int'(card_flower), dec_f[i]);
                            chk("decode_number", int'(card_number), dec_n[i]);
                        end
                    end
                    if (h.run == 0 && card_bit < 6'd52) begin
                        chk("duplicate_card", int'(seen[card_bit]), 0);
                        seen[card_bit] = 1'b1;
                        if (h.idx < 8) first_run[h.idx] = int'(card_bit);
                    end
                    if (h.run == 2 && h.idx < 8)
                        chk("determinism", int'(card_bit), first_run[h.idx]);
                end
            end
        end else if (q.size() > 0 && q[0].kind != K_STAT && cyc > q[0].cyc) begin
            h = q.pop_front();
            chk((h.kind == K_ACK) ? "ack_timeout" : "nack_timeout",
                (h.kind == K_ACK) ? int'(deal_ack) : int'(deal_nack), 1);
        end
    end

    initial begin
        run = 0;
        do_reset();
        for (int i = 0; i < 52; i++) do_deal(i % NP, 0, i);
        run = 1;
        do_deal(0, 1, 0);
        nr_pulse(1'b1);
        for (int i = 0; i < 3; i++) do_deal(i % NP, 1, i);
        nr_abort(1);
        for (int i = 0; i < 16; i++) do_deal(0, 1, i);
        run = 2;
        rst_abort();
        for (int i = 0; i < 8; i++) do_deal(i % NP, 2, i);
        repeat (80) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
# card_dealer

Controller that deals cards from one 52-card deck to up to NUM_PLAYERS requesters without duplicates. It picks a pseudo-random undealt index with a free-running LFSR, resolves collisions by linear probing over a 52-bit used mask, and decodes the winner into suit and rank. It returns the result with a one-cycle acknowledge. It sits between the game-control FSM (requester) and the display/scoring logic that consumes card_flower/card_number.

## Interface
- NUM_PLAYERS, 4, number of requesters; player id width is clog2(NUM_PLAYERS).
- LFSR_SEED, 8'hA5, LFSR value loaded on reset; must be nonzero.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- new_round  in  1  pulse; returns all cards to the deck and clears hand counts.
- deal_req  in  1  level request; sampled only in IDLE.
- deal_player  in  clog2(NUM_PLAYERS)  requesting player; captured with deal_req.
- deal_ack  out  1  one-cycle pulse; card outputs are valid in this cycle and held afterwards.
- deal_nack  out  1  one-cycle pulse; request refused because the deck is empty.
- card_bit  out  6  dealt card index, 0..51.
- card_flower  out  2  suit, card_bit / 13.
- card_number  out  4  rank, card_bit % 13.
- card_player  out  clog2(NUM_PLAYERS)  player the card was dealt to.
- cards_left  out  6  undealt cards, 52..0.
- deck_empty  out  1  high when cards_left == 0.
- hand_count  out  4*NUM_PLAYERS  packed per-player dealt counts; player p occupies [4p+3:4p]; each count saturates at 15.
- busy  out  1  high in PICK/PROBE/DONE.

## Operation
- Reset values:
  - deal_ack, deal_nack, busy, card_* and hand_count are 0.
  - cards_left = 52; deck_empty = 0.
  - used mask is all 0; lfsr = LFSR_SEED; state = IDLE.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every cycle, including during reset deassertion cycles and busy states.
  - Never reaches 0.
- FSM states:
  - IDLE:
    - If new_round is high, clear the mask and counters and stay in IDLE.
    - Else, if deal_req is high and deck_empty is high, pulse deal_nack and stay in IDLE.
    - Else, if deal_req is high, capture deal_player and go to PICK.
  - PICK: cand = lfsr[5:0] if lfsr[5:0] < 52, else lfsr[5:0] − 52. Go to PROBE.
  - PROBE:
    - If used[cand] is 0, set used[cand] and go to DONE.
    - Else cand = (cand == 51) ? 0 : cand + 1 and stay in PROBE.
  - DONE:
    - Register card_bit = cand and the decoded flower/number; card_player = captured id.
    - Pulse deal_ack, decrement cards_left, and increment hand_count[player] (saturating).
    - Go to IDLE.
- Decode: flower by threshold compare (≥39 → 3, ≥26 → 2, ≥13 → 1, else 0); number = cand − 13·flower. Division and modulo operators are not used.
- new_round in any state:
  - Aborts the deal in progress; no ack is issued.
  - Clears the mask, sets cards_left = 52, clears hand_count, and returns to IDLE on the next edge.
  - Takes priority over deal_req in the same cycle.
  - card_* outputs keep their last values.
- Requester rule: hold deal_req until ack or nack, then drop it. A request still high in the IDLE cycle after ack is a new deal.
- Changes to deal_player while busy are ignored.

## Timing
- Latency from deal_req sampled in IDLE to deal_ack: 3 + k cycles. k is the number of occupied slots probed, 0..51, so the worst case is 54 cycles.
- deal_nack arrives 1 cycle after the request is sampled.
- Back-to-back deals: minimum request-to-request spacing is 4 cycles (IDLE, PICK, PROBE, DONE).
- cards_left, deck_empty and hand_count update on the same edge that raises deal_ack.
- deck_empty is a combinational function of cards_left; card_* outputs are registered.
- rst asserted mid-deal: next edge restores all reset values; no ack.
- Probe termination: PROBE is entered only with cards_left > 0, so a free slot is guaranteed within 52 probes.

## Structure
- Shared package card_pkg:
  - DECK_SIZE = 52, SUIT_SIZE = 13.
  - Index/suit/rank widths (6/2/4).
  - FSM state enum (IDLE, PICK, PROBE, DONE).
  - LFSR tap constant.
- Sub-module card_decode: purely combinational, 6-bit index → 2-bit suit and 4-bit rank. Shared with other blocks that decode card indices.
- The LFSR, used mask and FSM live in card_dealer.

## Test plan
- Reset, then 52 deals alternating players 0..3 → 52 acks, all card_bit values distinct and covering 0..51. Afterwards cards_left = 0, deck_empty = 1, hand_count = {13,13,13,13}.
- 53rd request → deal_nack pulse 1 cycle after sampling; no ack; state unchanged.
- Decode check on every ack: card_bit 0 → (0,0); 12 → (0,12); 13 → (1,0); 38 → (2,12); 51 → (3,12).
- Collision and wrap: after 51 deals, the 52nd deal lands on the single remaining index. Ack latency equals 3 + (probe distance with wrap 51→0) and is ≤ 54 cycles.
- new_round asserted during PROBE → no ack. Next cycle: IDLE, cards_left = 52, hand_count = 0. A following deal succeeds.
- rst mid-deal, then re-run with the same LFSR_SEED and identical request timing → identical card sequence to the first run (determinism).
